// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the unified-memory arbiter: request/ack handshake plus
// address, write data and read data.
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input  ack);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output rdata, output ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// arbitration, variable-latency handshake, timeout abort and pipeline stall.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int FAIR    = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_valid_o,
  output logic        stall_o,
  output logic        timeout_o,
  mem_port_arbiter_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic       SIDE_IF = 1'b0;
  localparam logic       SIDE_DM = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        timeout_q, timeout_d;

  logic elig_if, elig_dm, gnt_dm, gnt_if;

  // A side whose valid is pulsing this cycle is masked, so the other side
  // can be granted in the RESP cycle and neither starves.
  assign elig_if = if_req_i & ~if_valid_o;
  assign elig_dm = dm_req_i & ~dm_valid_o;
  assign gnt_dm  = elig_dm & (~elig_if | (FAIR == 0) | (last_q == SIDE_IF));
  assign gnt_if  = elig_if & ~gnt_dm;

  assign stall_o = elig_if | elig_dm;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      last_q     <= SIDE_IF;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (gnt_dm) begin
          state_d = BUSY_D;
          last_d  = SIDE_DM;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = dm_we_i;
          addr_d  = dm_addr_i & ~32'h3;
          wdata_d = dm_wdata_i;
        end else if (gnt_if) begin
          state_d = BUSY_I;
          last_d  = SIDE_IF;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i & ~32'h3;
          wdata_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (state_q == BUSY_I)  if_rdata_d = mem.rdata;
          else if (!we_q)         dm_rdata_d = mem.rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d   = RESP;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          if (state_q == BUSY_I)  if_rdata_d = '0;
          else if (!we_q)         dm_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_valid_o = (state_q == RESP) & (last_q == SIDE_IF);
    dm_valid_o = (state_q == RESP) & (last_q == SIDE_DM);
  end

  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign timeout_o  = timeout_q;
  assign mem.req    = req_q;
  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 0 uses FAIR=0/TIMEOUT=64, instance 1 FAIR=1/TIMEOUT=4.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic [31:0] if_rdata [2];
  logic        if_valid [2];
  logic        dm_req   [2];
  logic        dm_we    [2];
  logic [31:0] dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] dm_rdata [2];
  logic        dm_valid [2];
  logic        stall    [2];
  logic        tmo      [2];
  logic        mreq     [2];
  logic        mwe      [2];
  logic [31:0] maddr    [2];
  logic [31:0] mwdata   [2];
  logic [31:0] mrdata   [2];
  logic        mack     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter_if u_if ();
    mem_port_arbiter #(.TIMEOUT(g == 0 ? 64 : 4), .FAIR(g)) u_dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .if_req_i  (if_req[g]),
      .if_addr_i (if_addr[g]),
      .if_rdata_o(if_rdata[g]),
      .if_valid_o(if_valid[g]),
      .dm_req_i  (dm_req[g]),
      .dm_we_i   (dm_we[g]),
      .dm_addr_i (dm_addr[g]),
      .dm_wdata_i(dm_wdata[g]),
      .dm_rdata_o(dm_rdata[g]),
      .dm_valid_o(dm_valid[g]),
      .stall_o   (stall[g]),
      .timeout_o (tmo[g]),
      .mem       (u_if)
    );
    assign u_if.rdata = mrdata[g];
    assign u_if.ack   = mack[g];
    assign mreq[g]    = u_if.req;
    assign mwe[g]     = u_if.we;
    assign maddr[g]   = u_if.addr;
    assign mwdata[g]  = u_if.wdata;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first BUSY cycle; holds the ack off for lat-1 cycles,
  // then acks and returns in the RESP cycle.
  task automatic serve(input int k, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] rd, input string tag);
    for (int i = 1; i <= lat; i++) begin
      chk({tag, "_req"},  32'(mreq[k]), 32'd1);
      chk({tag, "_addr"}, maddr[k], a);
      chk({tag, "_we"},   32'(mwe[k]), 32'(w));
      if (w) chk({tag, "_wdata"}, mwdata[k], wd);
      if (i == lat) begin
        mack[k]   = 1'b1;
        mrdata[k] = rd;
      end
      tick();
    end
    mack[k]   = 1'b0;
    mrdata[k] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
      dm_addr[k] = 0; dm_wdata[k] = 0; mrdata[k] = 0; mack[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mreq",   32'(mreq[k]), 0);
      chk("rst_maddr",  maddr[k], 0);
      chk("rst_mwe",    32'(mwe[k]), 0);
      chk("rst_mwdata", mwdata[k], 0);
      chk("rst_ifrd",   if_rdata[k], 0);
      chk("rst_dmrd",   dm_rdata[k], 0);
      chk("rst_ifv",    32'(if_valid[k]), 0);
      chk("rst_dmv",    32'(dm_valid[k]), 0);
      chk("rst_tmo",    32'(tmo[k]), 0);
      chk("rst_stall",  32'(stall[k]), 0);
    end
    rst_n = 1'b1;
    tick();

    // IF fetch, minimum latency
    if_req[0] = 1; if_addr[0] = 32'h4;
    #1 chk("t1_stall0", 32'(stall[0]), 1);
    tick();
    chk("t1_ifv1", 32'(if_valid[0]), 0);
    chk("t1_stall1", 32'(stall[0]), 1);
    serve(0, 32'h4, 0, 0, 1, 32'h13, "t1");
    chk("t1_ifv2", 32'(if_valid[0]), 1);
    chk("t1_ifrd", if_rdata[0], 32'h13);
    chk("t1_mreq2", 32'(mreq[0]), 0);
    chk("t1_stall2", 32'(stall[0]), 0);
    if_req[0] = 0;
    tick();
    chk("t1_ifv3", 32'(if_valid[0]), 0);

    // Simultaneous, FAIR=0: DM first, IF granted in DM's RESP cycle
    if_req[0] = 1; if_addr[0] = 32'h8;
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h200;
    tick();
    serve(0, 32'h200, 0, 0, 1, 32'hCAFE0001, "t2d");
    chk("t2_dmv", 32'(dm_valid[0]), 1);
    chk("t2_dmrd", dm_rdata[0], 32'hCAFE0001);
    chk("t2_ifv_lo", 32'(if_valid[0]), 0);
    dm_req[0] = 0;
    tick();
    serve(0, 32'h8, 0, 0, 2, 32'h93, "t2i");
    chk("t2_ifv", 32'(if_valid[0]), 1);
    chk("t2_ifrd", if_rdata[0], 32'h93);
    chk("t2_dmv_lo", 32'(dm_valid[0]), 0);
    if_req[0] = 0;
    tick();

    // Store with 5-cycle ack latency; load data must be untouched
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h103; dm_wdata[0] = 32'hDEADBEEF;
    tick();
    serve(0, 32'h100, 1, 32'hDEADBEEF, 5, 32'h55555555, "t3");
    chk("t3_dmv", 32'(dm_valid[0]), 1);
    chk("t3_dmrd", dm_rdata[0], 32'hCAFE0001);
    chk("t3_mreq", 32'(mreq[0]), 0);
    dm_req[0] = 0; dm_we[0] = 0; dm_wdata[0] = 0;
    tick();
    chk("t3_dmv_once", 32'(dm_valid[0]), 0);

    // Back-to-back DM with IF held: IF slots in between
    if_req[0] = 1; if_addr[0] = 32'hC;
    dm_req[0] = 1; dm_addr[0] = 32'h300;
    tick();
    serve(0, 32'h300, 0, 0, 1, 32'hA1, "t4d");
    chk("t4_dmv", 32'(dm_valid[0]), 1);
    chk("t4_dmrd", dm_rdata[0], 32'hA1);
    dm_addr[0] = 32'h304;
    tick();
    serve(0, 32'hC, 0, 0, 1, 32'hB2, "t4i");
    chk("t4_ifv", 32'(if_valid[0]), 1);
    chk("t4_ifrd", if_rdata[0], 32'hB2);
    if_req[0] = 0;
    tick();
    serve(0, 32'h304, 0, 0, 1, 32'hC3, "t4d2");
    chk("t4_dmv2", 32'(dm_valid[0]), 1);
    chk("t4_dmrd2", dm_rdata[0], 32'hC3);
    dm_req[0] = 0;
    tick();
    chk("t4_stall", 32'(stall[0]), 0);
    chk("t4_mreq", 32'(mreq[0]), 0);

    // Instance 1: load, then timeout, then FAIR tie after a DM grant
    dm_req[1] = 1; dm_addr[1] = 32'h40;
    tick();
    serve(1, 32'h40, 0, 0, 1, 32'h12345678, "t5a");
    chk("t5a_dmrd", dm_rdata[1], 32'h12345678);
    dm_req[1] = 0;
    tick();
    dm_req[1] = 1; dm_addr[1] = 32'h44;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("t5_to_mreq", 32'(mreq[1]), 1);
      chk("t5_to_flag_lo", 32'(tmo[1]), 0);
      chk("t5_to_dmv_lo", 32'(dm_valid[1]), 0);
      tick();
    end
    chk("t5_to_mreq_drop", 32'(mreq[1]), 0);
    chk("t5_to_flag", 32'(tmo[1]), 1);
    chk("t5_to_dmv", 32'(dm_valid[1]), 1);
    chk("t5_to_dmrd", dm_rdata[1], 0);
    dm_req[1] = 0;
    tick();
    chk("t5_to_sticky", 32'(tmo[1]), 1);
    chk("t5_to_dmv_once", 32'(dm_valid[1]), 0);
    if_req[1] = 1; if_addr[1] = 32'h8;
    dm_req[1] = 1; dm_addr[1] = 32'h200;
    tick();
    serve(1, 32'h8, 0, 0, 1, 32'h77, "t5i");
    chk("t5_ifv", 32'(if_valid[1]), 1);
    chk("t5_ifrd", if_rdata[1], 32'h77);
    chk("t5_tmo_kept", 32'(tmo[1]), 1);
    if_req[1] = 0;
    tick();
    serve(1, 32'h200, 0, 0, 1, 32'h88, "t5d");
    chk("t5_dmv", 32'(dm_valid[1]), 1);
    chk("t5_dmrd", dm_rdata[1], 32'h88);
    dm_req[1] = 0;
    tick();

    // Asynchronous reset in the middle of a data access
    dm_req[0] = 1; dm_addr[0] = 32'h80;
    tick();
    chk("t6_mreq_busy", 32'(mreq[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mreq", 32'(mreq[0]), 0);
    chk("t6_maddr", maddr[0], 0);
    chk("t6_dmv", 32'(dm_valid[0]), 0);
    chk("t6_ifv", 32'(if_valid[0]), 0);
    chk("t6_dmrd", dm_rdata[0], 0);
    chk("t6_tmo1", 32'(tmo[1]), 0);
    dm_req[0] = 0;
    tick();
    rst_n = 1'b1;
    mack[0] = 1; mrdata[0] = 32'hFFFF;
    tick();
    chk("t6_late_ack_dmv", 32'(dm_valid[0]), 0);
    chk("t6_late_ack_mreq", 32'(mreq[0]), 0);
    mack[0] = 0; mrdata[0] = 0;
    tick();
    chk("t6_dmv_after", 32'(dm_valid[0]), 0);
    chk("t6_dmrd_after", dm_rdata[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Arbitrates the two requests, sequences each access through a variable-latency memory handshake, and returns data to the requester.
- Drives a pipeline stall while any request is outstanding, and detects memory timeouts.
- Sits between the PC/IF/MEM pipeline logic and the external memory model.

Parameters:
- TIMEOUT, 64, maximum cycles mem_req_o may stay high without mem_ack_i before the access is aborted (range 2..255).
- FAIR, 0, 0 = data side always wins a tie; 1 = on a tie, the side not granted last wins.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held high until if_valid_o.
- if_addr_i  in  32  fetch byte address.
- if_rdata_o  out  32  fetched instruction.
- if_valid_o  out  1  one-cycle pulse: fetch complete, if_rdata_o valid.
- dm_req_i  in  1  data request; held high until dm_valid_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  32  data byte address.
- dm_wdata_i  in  32  store data.
- dm_rdata_o  out  32  load data.
- dm_valid_o  out  1  one-cycle pulse: data access complete.
- stall_o  out  1  pipeline freeze.
- mem_req_o  out  1  memory request; held until ack or abort.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  word-aligned memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion from memory.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State IDLE; all outputs 0, including rdata outputs, mem_* outputs and timeout_o.
  - Last-grant register = IF; timeout counter = 0.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Eligible requesters are the req_i inputs, with a requester masked in the cycle its own valid_o is high.
  - If none is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible: with FAIR=0, grant DM; with FAIR=1, grant the side opposite the last grant.
  - On grant: latch addr (bits [1:0] forced to 0), we (forced 0 for IF) and wdata into mem_* registers. Set mem_req_o=1 on the next edge, update the last-grant register, clear the counter, and go to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_req_o stays 1; mem_addr_o, mem_we_o and mem_wdata_o are stable. The counter increments each cycle.
  - On mem_ack_i:
    - mem_req_o goes to 0 on the next edge.
    - For IF, or a DM load, capture mem_rdata_i into the granted side's rdata_o.
    - For a store, dm_rdata_o is unchanged.
    - Go to RESP.
  - If the counter reaches TIMEOUT-1 with no ack: drop mem_req_o, set timeout_o=1, load 0 into the granted side's rdata_o (loads and fetches only), and go to RESP.
- RESP:
  - Exactly one cycle; the granted side's valid_o = 1.
  - Return to IDLE, whose first cycle overlaps this one: a new grant may be made in the RESP cycle from the other requester only. The just-served requester is masked.
  - This gives minimum latency: request in cycle 0 → mem_req_o in cycle 1 → ack in cycle 1 → valid in cycle 2.
- Control and data rules:
  - Acks arriving in IDLE or RESP are ignored.
  - A request dropped mid-access does not cancel it; the access completes and valid still pulses.
  - stall_o = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o), combinational.
  - timeout_o clears only on reset.
  - No combinational path exists from mem_ack_i or mem_rdata_i to any output other than stall_o, which depends only on the req inputs and registered valids.

Test Plan:
- Reset → all outputs 0. Then IF request at 0x0000_0004 with ack after 1 cycle, mem_rdata_i=0x0000_0013 → mem_addr_o=0x4, mem_we_o=0, if_rdata_o=0x13, if_valid_o pulses 2 cycles after the request, stall_o high until that pulse.
- DM store addr 0x103, wdata 0xDEADBEEF, ack latency 5 → mem_addr_o=0x100, mem_we_o=1, mem_wdata_o=0xDEADBEEF held for 5 cycles, dm_valid_o pulses once, dm_rdata_o unchanged.
- Simultaneous IF (0x8) and DM load (0x200):
  - FAIR=0 → DM served first, then IF granted in DM's RESP cycle.
  - FAIR=1 with last grant DM → IF served first.
- Back-to-back DM requests with FAIR=0 and IF held high → IF is served between them (masking), so it is not starved.
- TIMEOUT=4 with no ack → mem_req_o drops after 4 cycles, timeout_o=1 and stays set, dm_valid_o pulses with dm_rdata_o=0; the next access completes normally.
- Assert rst_i low during BUSY_D → mem_req_o and all valids are 0 immediately (asynchronously), state IDLE; an ack arriving after reset is released produces no valid.
